// File: rtl/ltl_mon_pkg.sv
// Shared types for the programmable LTL monitor automaton.
// No logic; enums and limits only.
// Imported by ltl_mon_ste and ltl_monitor_automaton.
package ltl_mon_pkg;

    localparam int MAX_STE = 64;

    typedef enum logic [1:0] {
        START_NONE    = 2'd0,
        START_OF_DATA = 2'd1,
        START_ALL     = 2'd2
    } start_type_e;

    typedef enum logic [1:0] {
        CFG_MATCH  = 2'd0,
        CFG_EDGE   = 2'd1,
        CFG_START  = 2'd2,
        CFG_REPORT = 2'd3
    } cfg_sel_e;

endpackage

// File: rtl/ltl_mon_ste.sv
// One state-transition element: match bitmap, incoming edge row, start type, active flop.
// Latency: active updates at the edge after a run cycle.
// Backpressure: none; steps only when run=1, otherwise holds.
module ltl_mon_ste
    import ltl_mon_pkg::*;
#(
    parameter int N_STE = 16,
    parameter int SYM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             sod,
    input  logic [SYM_W-1:0] symbols,
    input  logic [N_STE-1:0] active_vec,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [SYM_W-1:0] cfg_addr,
    input  logic [N_STE-1:0] cfg_wdata,
    output logic             active
);

    logic [2**SYM_W-1:0] bitmap;
    logic [N_STE-1:0]    edge_row;
    start_type_e         start_type;
    logic                st_hit;
    logic                enabled;

    // Tables are configuration, not state: reset leaves them untouched.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            case (cfg_sel)
                CFG_MATCH: bitmap[cfg_addr] <= cfg_wdata[0];
                CFG_EDGE:  edge_row         <= cfg_wdata;
                CFG_START: start_type       <= start_type_e'(cfg_wdata[1:0]);
                default:   ;
            endcase
        end
    end

    always_comb begin
        st_hit = 1'b0;
        case (start_type)
            START_OF_DATA: st_hit = sod;
            START_ALL:     st_hit = 1'b1;
            default:       st_hit = 1'b0;
        endcase
    end

    assign enabled = (|(edge_row & active_vec)) | st_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
        end else if (run) begin
            active <= bitmap[symbols] & enabled;
        end
    end

endmodule

// File: rtl/ltl_monitor_automaton.sv
// Runtime-programmable homogeneous LTL monitor automaton; LTL_MON_REPORT_CNT_EN adds a report counter.
// Latency: symbol at cycle t -> active/report at t+1; report is combinational from active.
// Backpressure: none; run qualifies each symbol, config writes only accepted while run=0.
module ltl_monitor_automaton
    import ltl_mon_pkg::*;
#(
    parameter int N_STE = 16,
    parameter int SYM_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [SYM_W-1:0]         symbols,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_sel,
    input  logic [$clog2(N_STE)-1:0] cfg_ste,
    input  logic [SYM_W-1:0]         cfg_addr,
    input  logic [N_STE-1:0]         cfg_wdata,
    output logic                     cfg_err,
    output logic [N_STE-1:0]         active,
    output logic [N_STE-1:0]         report,
    output logic                     report_any,
    output logic [CNT_W-1:0]         report_cnt
);

    localparam int STE_W = $clog2(N_STE);

    logic             sod_pending;
    logic             sod;
    logic             ste_ok;
    logic             cfg_ok;
    logic [N_STE-1:0] report_mask;

    assign ste_ok = int'(cfg_ste) < N_STE;
    assign cfg_ok = cfg_we & ~run & ste_ok;
    assign sod    = sod_pending & run;

    always_ff @(posedge clk) begin
        if (reset) begin
            sod_pending <= 1'b1;
            cfg_err     <= 1'b0;
        end else begin
            if (run) begin
                sod_pending <= 1'b0;
            end
            cfg_err <= cfg_we & (run | ~ste_ok);
        end
    end

    // A legal write commits even while reset is asserted.
    always_ff @(posedge clk) begin
        if (cfg_ok && cfg_sel == CFG_REPORT) begin
            report_mask[cfg_ste] <= cfg_wdata[0];
        end
    end

    for (genvar i = 0; i < N_STE; i++) begin : g_ste
        ltl_mon_ste #(
            .N_STE(N_STE),
            .SYM_W(SYM_W)
        ) u_ste (
            .clk       (clk),
            .reset     (reset),
            .run       (run),
            .sod       (sod),
            .symbols   (symbols),
            .active_vec(active),
            .cfg_we    (cfg_ok && (cfg_ste == STE_W'(i))),
            .cfg_sel   (cfg_sel),
            .cfg_addr  (cfg_addr),
            .cfg_wdata (cfg_wdata),
            .active    (active[i])
        );
    end

    assign report     = active & report_mask;
    assign report_any = |report;

`ifdef LTL_MON_REPORT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            report_cnt <= '0;
        end else if (run && report_any && !(&report_cnt)) begin
            report_cnt <= report_cnt + 1'b1;
        end
    end
`else
    assign report_cnt = '0;
`endif

endmodule
